btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Input conditioning stage between the board push-buttons (BtnU/BtnD/BtnL/BtnR/BtnC) and the game logic (block_controller) in the VGA top level. It synchronizes each raw button into the system clock domain and debounces it with a per-button state machine. For every button it produces a clean level, single-cycle press and release pulses, and optional auto-repeat pulses while the button is held. All outputs are in the 100 MHz ClkPort domain. Level outputs may be sampled safely by slower-clocked consumers such as the move_clk logic.

## Interface
- N_BTN, 5, number of independent button channels
- DEBOUNCE_CYCLES, 1_000_000, stable-input cycles required to accept a change (10 ms at 100 MHz); must be ≥ 2
- REPEAT_DELAY, 50_000_000, held cycles after the press pulse before the first repeat pulse (0.5 s)
- REPEAT_PERIOD, 10_000_000, cycles between subsequent repeat pulses (0.1 s); must be ≥ 2
- REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = btn_repeat is tied low and the hold states are not left for repeat

- clk  in  1  system clock (ClkPort, 100 MHz)
- rst  in  1  synchronous, active-high reset
- btn_in  in  N_BTN  raw asynchronous button inputs, active-high
- btn_level  out  N_BTN  debounced button state
- btn_press  out  N_BTN  one-cycle pulse on each accepted press
- btn_release  out  N_BTN  one-cycle pulse on each accepted release
- btn_repeat  out  N_BTN  one-cycle pulse per auto-repeat tick
- btn_step  out  N_BTN  btn_press | btn_repeat, registered for the movement logic

## Operation
- **Synchronizer.** Each channel has two flops, s1 ← btn_in and s2 ← s1. `sync` = s2. Both flops reset to 0.
- **Per-channel FSM.** Each channel has its own counter. Counter width is clog2 of max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD). The counter saturates at no point: every terminal count causes a transition that clears it.
- **IDLE** (level = 0)
  - sync = 1 → WAIT_PRESS, cnt ← 0.
- **WAIT_PRESS**
  - sync = 0 → IDLE, cnt ← 0 (bounce rejected, no output).
  - Otherwise, cnt = DEBOUNCE_CYCLES−1 → HELD: level ← 1, press pulse, cnt ← 0.
  - Otherwise cnt++.
- **HELD** (level = 1)
  - sync = 0 → WAIT_RELEASE, cnt ← 0.
  - Otherwise, REPEAT_EN and cnt = REPEAT_DELAY−1 → REPEAT: repeat pulse, cnt ← 0.
  - Otherwise cnt++.
- **REPEAT** (level = 1)
  - sync = 0 → WAIT_RELEASE, cnt ← 0.
  - Otherwise, cnt = REPEAT_PERIOD−1: repeat pulse, cnt ← 0, stay in REPEAT.
  - Otherwise cnt++.
- **WAIT_RELEASE** (level = 1)
  - sync = 1 → HELD, cnt ← 0. The repeat delay restarts; no press pulse is generated.
  - Otherwise, cnt = DEBOUNCE_CYCLES−1 → IDLE: level ← 0, release pulse, cnt ← 0.
  - Otherwise cnt++.
- **Channel independence.** Channels are fully independent. Simultaneous presses on several channels each produce their own pulses in the same cycle.
- **Output registers.** All outputs are registered. Pulses are exactly one clk cycle wide.
- **Pulse exclusivity.** press and repeat never coincide on a channel. btn_step is asserted whenever either one is.

## Timing
- **Reset.** On rst, every state returns to IDLE and every counter clears. Both synchronizer flops clear. btn_level, btn_press, btn_release, btn_repeat and btn_step are all 0 from the first edge with rst high.
  - Reset mid-count or mid-hold discards the event; no release pulse is emitted.
  - After rst deasserts, a button already held produces a press DEBOUNCE_CYCLES+3 edges later.
- **Press latency.** Let edge 1 be the first edge at which btn_in is sampled 1 and stays 1. btn_press and btn_level rise after edge DEBOUNCE_CYCLES+3: 2 synchronizer edges, 1 IDLE→WAIT_PRESS edge, then DEBOUNCE_CYCLES counting edges.
- **Release latency.** Release mirrors press: DEBOUNCE_CYCLES+3 edges after btn_in falls stably.
- **First repeat.** The first btn_repeat comes exactly REPEAT_DELAY cycles after btn_press.
- **Subsequent repeats.** Later repeats are every REPEAT_PERIOD cycles.
- **Minimum high time.** An input high for fewer than DEBOUNCE_CYCLES+1 consecutive sampled cycles produces no output.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_BTN=5.
- **Reset.** Assert rst for 3 cycles with btn_in=5'b11111. All outputs are 0 during reset. btn_press=5'b11111 for exactly one cycle, 7 edges after rst deasserts.
- **Clean press.** btn_in[0] goes 0→1 and is held. btn_press[0] and btn_step[0] pulse after edge 7, btn_level[0]=1 from then on, and all other bits stay 0.
- **Bounce rejection.** btn_in[2] toggles 1,1,1,0,1,1,0 (runs shorter than 5 cycles) and then stays 0. Every output bit 2 stays 0 throughout.
- **Auto-repeat.** Hold btn_in[1] for 30 cycles after its press pulse at cycle P. btn_repeat[1] pulses at P+10, P+13, P+16, …. btn_step[1] pulses at P and at every repeat.
- **Release with bounce.** While held, btn_in[3] goes 0 for 2 cycles, then 1, then 0 permanently. No release pulse occurs on the short drop. btn_release[3] pulses 7 edges after the final fall, and btn_level[3] goes 0 in the same cycle.
- **Simultaneous events and mid-operation reset.**
  - btn_in[4] and btn_in[0] rise together: both press bits pulse in the same cycle.
  - rst pulsed while btn 4 is in REPEAT: btn_level[4] goes 0 with no release pulse, and the press re-triggers 7 edges after rst deasserts.

Source files
------------

// File: rtl/btn_conditioner.sv
// Push-button conditioning: two-flop synchronizer plus a debounce FSM per channel.
// The FSM produces a clean level, press/release pulses and auto-repeat pulses.
module btn_conditioner #(
    parameter int unsigned N_BTN           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic [N_BTN-1:0] btn_step
);

    localparam int unsigned MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned CNT_MAX = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int unsigned CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PRESS,
        ST_HELD,
        ST_REPEAT,
        ST_WAIT_RELEASE
    } state_t;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        state_t        r_state;
        state_t        w_state_nxt;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_cnt_nxt;
        logic          r_level;
        logic          r_press;
        logic          r_release;
        logic          r_repeat;
        logic          r_step;
        logic          w_level_nxt;
        logic          w_press_nxt;
        logic          w_release_nxt;
        logic          w_repeat_nxt;
        logic          w_sync;

        assign w_sync = r_sync2[g];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_repeat  <= 1'b0;
                r_step    <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_level   <= w_level_nxt;
                r_press   <= w_press_nxt;
                r_release <= w_release_nxt;
                r_repeat  <= w_repeat_nxt;
                r_step    <= w_press_nxt | w_repeat_nxt;
            end
        end

        always_comb begin
            w_state_nxt   = r_state;
            w_cnt_nxt     = r_cnt + 1'b1;
            w_level_nxt   = r_level;
            w_press_nxt   = 1'b0;
            w_release_nxt = 1'b0;
            w_repeat_nxt  = 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_sync) w_state_nxt = ST_WAIT_PRESS;
                end
                ST_WAIT_PRESS: begin
                    if (!w_sync) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == DEB_LAST) begin
                        w_state_nxt = ST_HELD;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b1;
                        w_press_nxt = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!w_sync) begin
                        w_state_nxt = ST_WAIT_RELEASE;
                        w_cnt_nxt   = '0;
                    end else if (REPEAT_EN && (r_cnt == DLY_LAST)) begin
                        w_state_nxt  = ST_REPEAT;
                        w_cnt_nxt    = '0;
                        w_repeat_nxt = 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!w_sync) begin
                        w_state_nxt = ST_WAIT_RELEASE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == PER_LAST) begin
                        w_cnt_nxt    = '0;
                        w_repeat_nxt = 1'b1;
                    end
                end
                ST_WAIT_RELEASE: begin
                    // A return to 1 restarts the hold timing without a new press.
                    if (w_sync) begin
                        w_state_nxt = ST_HELD;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == DEB_LAST) begin
                        w_state_nxt   = ST_IDLE;
                        w_cnt_nxt     = '0;
                        w_level_nxt   = 1'b0;
                        w_release_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign btn_level[g]   = r_level;
        assign btn_press[g]   = r_press;
        assign btn_release[g] = r_release;
        assign btn_repeat[g]  = r_repeat;
        assign btn_step[g]    = r_step;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timing.
// Expected pulse positions are edge counts derived by hand from the timing rules.
module tb_btn_conditioner;

    localparam int unsigned N = 5;

    localparam int SEL_LEVEL   = 0;
    localparam int SEL_PRESS   = 1;
    localparam int SEL_RELEASE = 2;
    localparam int SEL_REPEAT  = 3;
    localparam int SEL_STEP    = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_repeat;
    logic [N-1:0] btn_step;

    int n_checks;
    int n_fail;

    btn_conditioner #(
        .N_BTN          (5),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .REPEAT_EN      (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat),
        .btn_step   (btn_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] pick(input int sel);
        case (sel)
            SEL_LEVEL:   return btn_level;
            SEL_PRESS:   return btn_press;
            SEL_RELEASE: return btn_release;
            SEL_REPEAT:  return btn_repeat;
            default:     return btn_step;
        endcase
    endfunction

    function automatic logic [31:0] bundle();
        return {7'd0, btn_level, btn_press, btn_release, btn_repeat, btn_step};
    endfunction

    // Tick n times; the selected output must equal expv at tick k and 0 otherwise.
    task automatic watch(input string tag, input int sel, input logic [N-1:0] expv,
                         input int k, input int n);
        for (int i = 1; i <= n; i++) begin
            tick();
            check_eq(tag, {27'd0, pick(sel)}, {27'd0, (i == k) ? expv : 5'b00000});
        end
    endtask

    initial begin
        logic [N-1:0] m;
        logic [N-1:0] e;
        n_checks = 0;
        n_fail   = 0;

        // Reset with all buttons held
        rst    = 1'b1;
        btn_in = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_outs_zero", bundle(), 32'd0);
        end
        rst = 1'b0;
        watch("rst_press", SEL_PRESS, 5'b11111, 7, 7);
        check_eq("rst_level", {27'd0, btn_level}, {27'd0, 5'b11111});
        check_eq("rst_step", {27'd0, btn_step}, {27'd0, 5'b11111});
        tick();
        check_eq("rst_press_gone", {27'd0, btn_press}, 32'd0);
        check_eq("rst_step_gone", {27'd0, btn_step}, 32'd0);
        btn_in = 5'b00000;
        watch("rst_all_release", SEL_RELEASE, 5'b11111, 7, 8);
        check_eq("rst_all_idle", bundle(), 32'd0);

        // Clean press on button 0
        btn_in = 5'b00001;
        watch("clean_press", SEL_PRESS, 5'b00001, 7, 7);
        check_eq("clean_level", {27'd0, btn_level}, {27'd0, 5'b00001});
        check_eq("clean_step", {27'd0, btn_step}, {27'd0, 5'b00001});
        tick();
        check_eq("clean_after", bundle(), {7'd0, 5'b00001, 20'd0});
        btn_in = 5'b00000;
        watch("clean_release", SEL_RELEASE, 5'b00001, 7, 8);
        check_eq("clean_idle", bundle(), 32'd0);

        // Bounce on button 2: no run long enough to be accepted
        m = 5'b00100;
        for (int i = 0; i < 17; i++) begin
            e = 5'b00000;
            if (i < 7) begin
                logic [6:0] pat;
                pat = 7'b1110110;
                e[2] = pat[6-i];
            end
            btn_in = m & e;
            tick();
            check_eq("bounce_quiet", bundle(), 32'd0);
        end

        // Auto-repeat on button 1
        btn_in = 5'b00010;
        watch("rep_press", SEL_PRESS, 5'b00010, 7, 7);
        for (int i = 1; i <= 30; i++) begin
            tick();
            e = (i >= 10 && ((i - 10) % 3) == 0) ? 5'b00010 : 5'b00000;
            check_eq("rep_repeat", {27'd0, btn_repeat}, {27'd0, e});
            check_eq("rep_step", {27'd0, btn_step}, {27'd0, e});
            check_eq("rep_level", {27'd0, btn_level}, {27'd0, 5'b00010});
        end
        btn_in = 5'b00000;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq("rep_tail_repeat", {27'd0, btn_repeat}, {27'd0, (i == 1) ? 5'b00010 : 5'b00000});
            check_eq("rep_release", {27'd0, btn_release}, {27'd0, (i == 7) ? 5'b00010 : 5'b00000});
        end
        check_eq("rep_idle", bundle(), 32'd0);

        // Release with a short drop on button 3
        btn_in = 5'b01000;
        watch("rb_press", SEL_PRESS, 5'b01000, 7, 7);
        btn_in = 5'b00000;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("rb_drop_norel", {27'd0, btn_release}, 32'd0);
        end
        btn_in = 5'b01000;
        tick();
        check_eq("rb_drop_level", {27'd0, btn_level}, {27'd0, 5'b01000});
        btn_in = 5'b00000;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq("rb_release", {27'd0, btn_release}, {27'd0, (i == 7) ? 5'b01000 : 5'b00000});
            check_eq("rb_level", {27'd0, btn_level}, {27'd0, (i < 7) ? 5'b01000 : 5'b00000});
            check_eq("rb_no_press", {27'd0, btn_press}, 32'd0);
        end

        // Simultaneous press on 4 and 0, then reset while in repeat
        m = 5'b10001;
        btn_in = m;
        watch("sim_press", SEL_PRESS, m, 7, 7);
        watch("sim_repeat", SEL_REPEAT, m, 10, 11);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("midrst_zero", bundle(), 32'd0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            logic [31:0] exp_b;
            tick();
            if (i == 7)      exp_b = {7'd0, m, m, 5'b00000, 5'b00000, m};
            else if (i == 8) exp_b = {7'd0, m, 20'd0};
            else             exp_b = 32'd0;
            check_eq("midrst_retrigger", bundle(), exp_b);
        end

        rst = 1'b1;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
